// File: rtl/auto_song_player_if.sv
// Control/status bundle between the piano mode FSM (master) and the
// AUTO-mode song player (slave).
interface auto_song_player_if;
  logic       enable;
  logic       pause;
  logic       signal;
  logic [3:0] note;
  logic [5:0] addr;
  logic       busy;
  logic       done;

  modport master (
    output enable, pause,
    input  signal, note, addr, busy, done
  );

  modport slave (
    input  enable, pause,
    output signal, note, addr, busy, done
  );
endinterface

// File: rtl/auto_song_player.sv
// AUTO-mode song sequencer: walks a {note, beats} table and drives the buzzer
// with a square wave at each note's pitch, with a silent gap after every note.
//
// state | meaning
// IDLE  | waiting for enable, addr parked at 0, buzzer silent
// FETCH | one cycle: read entry[addr], end marker or table end -> DONE
// PLAY  | tone generation for beats*BEAT_CYCLES cycles
// GAP   | GAP_CYCLES silent cycles, then next entry
// DONE  | song finished (LOOP restarts from entry 0)
module auto_song_player #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int BEAT_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 2_500_000,
  parameter int LOOP        = 0,
  parameter int SONG_LEN    = 64,
  // entry i lives at SONG_ROM[8*i +: 8]; unused entries hold the end marker
  parameter logic [511:0] SONG_ROM = {
    {50{8'hF0}},
    8'h12, 8'h21, 8'h21, 8'h31, 8'h31, 8'h41, 8'h41,
    8'h52, 8'h61, 8'h61, 8'h51, 8'h51, 8'h11, 8'h11
  }
) (
  input  logic              clk,
  input  logic              rst,
  auto_song_player_if.slave bus
);

  function automatic int calc_half(input int f_hz);
    int h;
    h = CLK_HZ / (2 * f_hz);
    return (h < 1) ? 1 : h;
  endfunction

  localparam int HALF_1  = calc_half(262);
  localparam int HALF_2  = calc_half(294);
  localparam int HALF_3  = calc_half(330);
  localparam int HALF_4  = calc_half(349);
  localparam int HALF_5  = calc_half(392);
  localparam int HALF_6  = calc_half(440);
  localparam int HALF_7  = calc_half(494);
  localparam int HALF_8  = calc_half(523);
  localparam int HALF_9  = calc_half(587);
  localparam int HALF_10 = calc_half(659);
  localparam int HALF_11 = calc_half(698);
  localparam int HALF_12 = calc_half(784);
  localparam int HALF_13 = calc_half(880);
  localparam int HALF_14 = calc_half(988);

  // C4 is the lowest pitch, so it sets the tone counter width
  localparam int TONE_W   = $clog2(HALF_1 + 1);
  localparam int DUR_MAX  = (15 * BEAT_CYCLES > GAP_CYCLES) ? 15 * BEAT_CYCLES : GAP_CYCLES;
  localparam int DUR_W    = $clog2(DUR_MAX + 1);
  localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [6:0]         addr_q, addr_d;
  logic [3:0]         note_q, note_d;
  logic [TONE_W-1:0]  tone_q, tone_d;
  logic               phase_q, phase_d;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic               signal_q, signal_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [7:0]         entry;
  logic [3:0]         beats_eff;
  logic [TONE_W-1:0]  half_m1;

  assign entry     = SONG_ROM[{addr_q[5:0], 3'b000} +: 8];
  assign beats_eff = (entry[3:0] == 4'd0) ? 4'd1 : entry[3:0];

  always_comb begin
    half_m1 = '0;
    case (note_q)
      4'd1:    half_m1 = TONE_W'(HALF_1 - 1);
      4'd2:    half_m1 = TONE_W'(HALF_2 - 1);
      4'd3:    half_m1 = TONE_W'(HALF_3 - 1);
      4'd4:    half_m1 = TONE_W'(HALF_4 - 1);
      4'd5:    half_m1 = TONE_W'(HALF_5 - 1);
      4'd6:    half_m1 = TONE_W'(HALF_6 - 1);
      4'd7:    half_m1 = TONE_W'(HALF_7 - 1);
      4'd8:    half_m1 = TONE_W'(HALF_8 - 1);
      4'd9:    half_m1 = TONE_W'(HALF_9 - 1);
      4'd10:   half_m1 = TONE_W'(HALF_10 - 1);
      4'd11:   half_m1 = TONE_W'(HALF_11 - 1);
      4'd12:   half_m1 = TONE_W'(HALF_12 - 1);
      4'd13:   half_m1 = TONE_W'(HALF_13 - 1);
      4'd14:   half_m1 = TONE_W'(HALF_14 - 1);
      default: half_m1 = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    note_d   = note_q;
    tone_d   = tone_q;
    phase_d  = phase_q;
    dur_d    = dur_q;
    signal_d = 1'b0;
    if (!bus.enable) begin
      state_d = S_IDLE;
      addr_d  = '0;
      note_d  = '0;
      tone_d  = '0;
      phase_d = 1'b0;
      dur_d   = '0;
    end else if (bus.pause &&
                 (state_q == S_FETCH || state_q == S_PLAY || state_q == S_GAP)) begin
      // everything holds; phase_q keeps the waveform position for resume
      state_d = state_q;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_FETCH;
        S_FETCH: begin
          if (entry[7:4] == 4'hF || addr_q >= 7'(SONG_LEN)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_PLAY;
            note_d  = entry[7:4];
            tone_d  = '0;
            phase_d = 1'b0;
            dur_d   = DUR_W'(beats_eff) * DUR_W'(BEAT_CYCLES) - DUR_W'(1);
          end
        end
        S_PLAY: begin
          if (note_q != 4'd0) begin
            if (tone_q == half_m1) begin
              tone_d  = '0;
              phase_d = ~phase_q;
            end else begin
              tone_d = tone_q + TONE_W'(1);
            end
          end
          if (dur_q == '0) begin
            state_d = S_GAP;
            dur_d   = DUR_W'(GAP_LOAD);
            note_d  = '0;
            tone_d  = '0;
            phase_d = 1'b0;
          end else begin
            dur_d    = dur_q - DUR_W'(1);
            signal_d = phase_d;
          end
        end
        S_GAP: begin
          if (dur_q == '0) begin
            state_d = S_FETCH;
            addr_d  = addr_q + 7'd1;
          end else begin
            dur_d = dur_q - DUR_W'(1);
          end
        end
        S_DONE: begin
          if (LOOP != 0) begin
            state_d = S_FETCH;
            addr_d  = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d == S_FETCH) || (state_d == S_PLAY) || (state_d == S_GAP);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      note_q   <= '0;
      tone_q   <= '0;
      phase_q  <= 1'b0;
      dur_q    <= '0;
      signal_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      note_q   <= note_d;
      tone_q   <= tone_d;
      phase_q  <= phase_d;
      dur_q    <= dur_d;
      signal_q <= signal_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.signal = signal_q;
  assign bus.note   = note_q;
  assign bus.addr   = addr_q[5:0];
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule
